// File: rtl/his_peak_builder.sv
// his_peak_builder
// Builds one histogram of TDC bins per pixel over a frame of ACQ_NUM
// acquisitions, then scans each pixel's histogram and reports its peak.
//
// state | meaning
// CLEAR | zero one pixel's bin counters per cycle, PIXEL_NUM cycles
// ACCUM | accept samples (pixel-major per acquisition), bump counters
// SCAN  | compare one bin per cycle, strobe one peak result per pixel
//
// Ports
//   clk         sole clock, rising edge
//   res         synchronous active-high reset
//   wr_en       sample qualifier, taken only while ready is high
//   data        raw TDC code, all-ones means no detection
//   ready       high while accumulating
//   peak_valid  one-cycle strobe per pixel result
//   peak_pixel  pixel index of the current result
//   peak_bin    bin holding the highest count (lowest bin on ties)
//   peak_count  count found in that bin
//   frame_done  one-cycle strobe with the last pixel's result
module his_peak_builder #(
    parameter int NP        = 10,
    parameter int BIN_SHIFT = 5,
    parameter int PIXEL_NUM = 4,
    parameter int ACQ_NUM   = 8,
    parameter int CNT_W     = 8,
    localparam int BIN_W    = NP - BIN_SHIFT,
    localparam int PIX_W    = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             wr_en,
    input  logic [NP-1:0]    data,
    output logic             ready,
    output logic             peak_valid,
    output logic [PIX_W-1:0] peak_pixel,
    output logic [BIN_W-1:0] peak_bin,
    output logic [CNT_W-1:0] peak_count,
    output logic             frame_done
);

    localparam int BINS  = 1 << BIN_W;
    localparam int ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {CLEAR = 2'd0, ACCUM = 2'd1, SCAN = 2'd2} stateType;

    stateType state, nextState;

    logic [CNT_W-1:0] histMem [PIXEL_NUM][BINS];

    // pixIdx is shared: clear pointer in CLEAR, sample pixel in ACCUM,
    // scanned pixel in SCAN. It always wraps back to 0 on leaving a state.
    logic [PIX_W-1:0] pixIdx;
    logic [ACQ_W-1:0] acqIdx;
    logic [BIN_W-1:0] binIdx;

    logic             pendValid;
    logic [PIX_W-1:0] pendPix;
    logic [BIN_W-1:0] pendBin;

    logic [CNT_W-1:0] maxCnt, baseCnt, scanVal, newCnt;
    logic [BIN_W-1:0] maxBin, baseBin, newBin;

    logic accept, lastPix, lastAcq, lastBin;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign ready   = (state == ACCUM);
    assign accept  = wr_en && (state == ACCUM);
    assign lastPix = (pixIdx == PIX_W'(PIXEL_NUM - 1));
    assign lastAcq = (acqIdx == ACQ_W'(ACQ_NUM - 1));
    assign lastBin = (binIdx == BIN_W'(BINS - 1));

    always_ff @(posedge clk) begin
        if (res) state <= CLEAR;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            CLEAR:   if (lastPix) nextState = ACCUM;
            ACCUM:   if (accept && lastPix && lastAcq) nextState = SCAN;
            SCAN:    if (lastPix && lastBin) nextState = CLEAR;
            default: nextState = CLEAR;
        endcase
    end

    // Scan compare. The counter write of the final sample lands on the first
    // SCAN edge, so a matching pending increment is folded into the read.
    always_comb begin
        scanVal = histMem[pixIdx][binIdx];
        if (pendValid && pendPix == pixIdx && pendBin == binIdx) scanVal = satInc(scanVal);
        baseCnt = (binIdx == '0) ? '0 : maxCnt;
        baseBin = (binIdx == '0) ? '0 : maxBin;
        newCnt  = baseCnt;
        newBin  = baseBin;
        if (scanVal > baseCnt) begin
            newCnt = scanVal;
            newBin = binIdx;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            pixIdx     <= '0;
            acqIdx     <= '0;
            binIdx     <= '0;
            pendValid  <= 1'b0;
            maxCnt     <= '0;
            maxBin     <= '0;
            peak_valid <= 1'b0;
            frame_done <= 1'b0;
            peak_pixel <= '0;
            peak_bin   <= '0;
            peak_count <= '0;
        end else begin
            peak_valid <= 1'b0;
            frame_done <= 1'b0;
            pendValid  <= accept && (data != '1);
            pendPix    <= pixIdx;
            pendBin    <= data[NP-1:BIN_SHIFT];
            case (state)
                CLEAR: begin
                    pixIdx <= lastPix ? '0 : pixIdx + 1'b1;
                    acqIdx <= '0;
                    binIdx <= '0;
                end
                ACCUM: begin
                    if (accept) begin
                        pixIdx <= lastPix ? '0 : pixIdx + 1'b1;
                        if (lastPix) acqIdx <= lastAcq ? '0 : acqIdx + 1'b1;
                    end
                end
                SCAN: begin
                    maxCnt <= newCnt;
                    maxBin <= newBin;
                    binIdx <= binIdx + 1'b1;
                    if (lastBin) begin
                        peak_valid <= 1'b1;
                        peak_pixel <= pixIdx;
                        peak_bin   <= newBin;
                        peak_count <= newCnt;
                        frame_done <= lastPix;
                        pixIdx     <= lastPix ? '0 : pixIdx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Histogram store has no reset; CLEAR wipes it before every frame.
    always_ff @(posedge clk) begin
        if (pendValid) histMem[pendPix][pendBin] <= satInc(histMem[pendPix][pendBin]);
        for (int b = 0; b < BINS; b++) begin
            if (state == CLEAR) histMem[pixIdx][b] <= '0;
        end
    end

endmodule

// File: tb/tb_his_peak_builder.sv
module tb_his_peak_builder;

    localparam int P    = 4;
    localparam int BINS = 32;

    typedef struct {
        int pix;
        int bin;
        int cnt;
        bit done;
    } expT;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       resAtEdge = 1'b1;
    logic       wrEnA = 1'b0, wrEnB = 1'b0;
    logic [9:0] dataA = '0, dataB = '0;

    logic       readyA, peakValidA, frameDoneA;
    logic [1:0] peakPixelA;
    logic [4:0] peakBinA;
    logic [7:0] peakCountA;
    logic       readyB, peakValidB, frameDoneB;
    logic [1:0] peakPixelB;
    logic [4:0] peakBinB;
    logic [2:0] peakCountB;

    his_peak_builder dutA (
        .clk(clk), .res(res), .wr_en(wrEnA), .data(dataA), .ready(readyA),
        .peak_valid(peakValidA), .peak_pixel(peakPixelA), .peak_bin(peakBinA),
        .peak_count(peakCountA), .frame_done(frameDoneA)
    );

    his_peak_builder #(.NP(10), .BIN_SHIFT(5), .PIXEL_NUM(4), .ACQ_NUM(10), .CNT_W(3)) dutB (
        .clk(clk), .res(res), .wr_en(wrEnB), .data(dataB), .ready(readyB),
        .peak_valid(peakValidB), .peak_pixel(peakPixelB), .peak_bin(peakBinB),
        .peak_count(peakCountB), .frame_done(frameDoneB)
    );

    always #5 clk = ~clk;

    int  cycle = 0;
    int  passCnt = 0;
    int  totalCnt = 0;
    expT expA[$];
    expT expB[$];
    int  frame[$];
    int  lastCyc[2];
    int  lastStrobe[2];
    int  heldPix[2], heldBin[2], heldCnt[2];
    bit  holdBad[2];

    always @(posedge clk) begin
        cycle++;
        resAtEdge <= res;
    end

    task automatic check(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    endtask

    task automatic finishRun();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    endtask

    // Reference: histogram per pixel from the ordered sample list, counts
    // capped at cntMax, peak = first bin reaching the maximum.
    function automatic void pushModel(input int s);
        int hist[P][BINS];
        int cntMax = (s == 0) ? 255 : 7;
        for (int p = 0; p < P; p++)
            for (int b = 0; b < BINS; b++) hist[p][b] = 0;
        for (int i = 0; i < frame.size(); i++) begin
            if (frame[i] != 1023 && hist[i % P][frame[i] / BINS] < cntMax)
                hist[i % P][frame[i] / BINS]++;
        end
        for (int p = 0; p < P; p++) begin
            expT e;
            e.pix = p; e.bin = 0; e.cnt = 0; e.done = (p == P - 1);
            for (int b = 0; b < BINS; b++) begin
                if (hist[p][b] > e.cnt) begin
                    e.cnt = hist[p][b];
                    e.bin = b;
                end
            end
            if (s == 0) expA.push_back(e);
            else        expB.push_back(e);
        end
    endfunction

    task automatic drive(input int s, input bit en, input int d);
        if (s == 0) begin wrEnA = en; dataA = 10'(d); end
        else        begin wrEnB = en; dataB = 10'(d); end
    endtask

    task automatic sendFrame(input int s, input int gapPct, input bit holdAfter, input bit doPush);
        if (doPush) pushModel(s);
        for (int i = 0; i < frame.size(); i++) begin
            bit taken = 1'b0;
            int tries = 0;
            while (!taken) begin
                bit en;
                bit rdy;
                @(negedge clk);
                en  = ($urandom_range(0, 99) >= gapPct);
                rdy = (s == 0) ? readyA : readyB;
                drive(s, en, en ? frame[i] : int'($urandom_range(0, 1023)));
                if (en && rdy) begin
                    taken = 1'b1;
                    lastCyc[s] = cycle;
                end
                tries++;
                if (tries > 400) begin
                    totalCnt++;
                    $display("FAIL send_timeout: dut %0d sample %0d never accepted", s, i);
                    finishRun();
                end
            end
        end
        if (holdAfter) begin
            bit sawLow = 1'b0;
            for (int t = 0; t < 1000; t++) begin
                bit rdy;
                @(negedge clk);
                rdy = (s == 0) ? readyA : readyB;
                if (!rdy) sawLow = 1'b1;
                if (sawLow && rdy) begin
                    drive(s, 1'b0, 0);
                    break;
                end
                drive(s, 1'b1, 108);
            end
        end else begin
            @(negedge clk);
            drive(s, 1'b0, 0);
        end
    endtask

    task automatic waitDrain(input int bound);
        for (int t = 0; t < bound && (expA.size() + expB.size()) != 0; t++) @(negedge clk);
    endtask

    task automatic monitor(input int s, input bit pv, input bit fd, input int pp, input int pb, input int pc);
        expT e;
        if (resAtEdge) begin
            heldPix[s] = pp; heldBin[s] = pb; heldCnt[s] = pc; holdBad[s] = 1'b0;
            return;
        end
        if (!pv) begin
            if (fd || pp != heldPix[s] || pb != heldBin[s] || pc != heldCnt[s]) holdBad[s] = 1'b1;
            return;
        end
        check($sformatf("hold_or_stray_done_%0d", s), int'(holdBad[s]), 0);
        holdBad[s] = 1'b0;
        if ((s == 0 ? expA.size() : expB.size()) == 0) begin
            check($sformatf("unexpected_peak_valid_%0d", s), 1, 0);
        end else begin
            e = (s == 0) ? expA.pop_front() : expB.pop_front();
            check($sformatf("peak_pixel_%0d", s), pp, e.pix);
            check($sformatf("peak_bin_%0d_px%0d", s, e.pix), pb, e.bin);
            check($sformatf("peak_count_%0d_px%0d", s, e.pix), pc, e.cnt);
            check($sformatf("frame_done_%0d_px%0d", s, e.pix), int'(fd), int'(e.done));
            if (e.pix != 0) check($sformatf("strobe_spacing_%0d", s), cycle - lastStrobe[s], BINS);
            if (e.done) check($sformatf("frame_latency_%0d", s), cycle - lastCyc[s], P * BINS + 1);
        end
        lastStrobe[s] = cycle;
        heldPix[s] = pp; heldBin[s] = pb; heldCnt[s] = pc;
    endtask

    always @(negedge clk) begin
        monitor(0, peakValidA, frameDoneA, int'(peakPixelA), int'(peakBinA), int'(peakCountA));
        monitor(1, peakValidB, frameDoneB, int'(peakPixelB), int'(peakBinB), int'(peakCountB));
    end

    task automatic fillRandom(input int acqN, input int pctMiss, input bit narrow);
        frame.delete();
        for (int i = 0; i < P * acqN; i++) begin
            if ($urandom_range(0, 99) < pctMiss) frame.push_back(1023);
            else if (narrow) frame.push_back(int'(($urandom_range(0, 2) + 8) * BINS + $urandom_range(0, 31)));
            else frame.push_back(int'($urandom_range(0, 1023)));
        end
    endtask

    task automatic checkOutputsZero(input string tag);
        check({tag, "_ready"}, int'(readyA), 0);
        check({tag, "_peak_valid"}, int'(peakValidA), 0);
        check({tag, "_frame_done"}, int'(frameDoneA), 0);
        check({tag, "_peak_pixel"}, int'(peakPixelA), 0);
        check({tag, "_peak_bin"}, int'(peakBinA), 0);
        check({tag, "_peak_count"}, int'(peakCountA), 0);
    endtask

    initial begin
        int lowCnt;
        repeat (3) @(negedge clk);
        checkOutputsZero("reset");
        check("reset_ready_b", int'(readyB), 0);

        res = 1'b0;
        lowCnt = 0;
        for (int t = 0; t < 20 && !readyA; t++) begin
            lowCnt++;
            @(negedge clk);
        end
        check("ready_low_cycles", lowCnt, P);

        // single hit pixel, others silent
        frame.delete();
        for (int a = 0; a < 8; a++)
            for (int p = 0; p < P; p++) frame.push_back(p == 0 ? 108 : 1023);
        sendFrame(0, 0, 1'b0, 1'b1);

        // tie between bins 2 and 20 on pixel 1
        frame.delete();
        for (int a = 0; a < 8; a++)
            for (int p = 0; p < P; p++)
                frame.push_back(p == 1 ? (a < 4 ? 64 : 640) : int'($urandom_range(0, 1023)));
        sendFrame(0, 30, 1'b0, 1'b1);

        for (int k = 0; k < 4; k++) begin
            fillRandom(8, 25, k[0]);
            sendFrame(0, 20, 1'b0, 1'b1);
        end

        // wr_en held through SCAN and CLEAR, then an all-miss frame
        fillRandom(8, 10, 1'b1);
        sendFrame(0, 0, 1'b1, 1'b1);
        frame.delete();
        for (int i = 0; i < P * 8; i++) frame.push_back(1023);
        sendFrame(0, 10, 1'b0, 1'b1);

        // reset after 5 accepted samples discards the partial frame
        waitDrain(3000);
        frame.delete();
        for (int i = 0; i < 5; i++) frame.push_back(108);
        sendFrame(0, 0, 1'b0, 1'b0);
        res = 1'b1;
        wrEnA = 1'b1;
        dataA = 10'd108;
        @(negedge clk);
        checkOutputsZero("midframe_reset");
        res = 1'b0;
        wrEnA = 1'b0;
        frame.delete();
        for (int a = 0; a < 8; a++)
            for (int p = 0; p < P; p++) frame.push_back(p == 2 ? 300 : 1023);
        sendFrame(0, 0, 1'b0, 1'b1);

        // saturating counters on the narrow instance
        frame.delete();
        for (int a = 0; a < 10; a++)
            for (int p = 0; p < P; p++) frame.push_back(p == 0 ? 108 : 1023);
        sendFrame(1, 0, 1'b0, 1'b1);
        fillRandom(10, 10, 1'b1);
        sendFrame(1, 15, 1'b0, 1'b1);

        waitDrain(3000);
        repeat (40) @(negedge clk);
        check("leftover_expected_results", expA.size() + expB.size(), 0);
        finishRun();
    end

endmodule
